// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// Frame-state encoding, line levels and parity.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int PAR_MAX_W = 16;

  // Zero-extension does not change the XOR reduction.
  function automatic logic parity_bit(
    input logic [PAR_MAX_W-1:0] data,
    input logic                 odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous register FIFO feeding the UART transmitter.
// Push is refused when full, pop is ignored when empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with input FIFO and baud divider.
// Frames run back to back while the FIFO holds words.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Data_Valid,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          Data_Ready,
  input  logic                          PAR_EN,
  input  logic                          PAR_TYP,
  input  logic                          STOP2,
  input  logic [DIV_WIDTH-1:0]          BAUD_DIV,
  output logic                          TX_OUT,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_tx_state_t state, state_n;

  logic [DIV_WIDTH-1:0]  timer, timer_n, div_q;
  logic [BW-1:0]         bit_q, bit_n;
  logic                  stop_q, stop_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  tx_q, tx_n;
  logic                  par_en_q, par_q, stop2_q;
  logic                  pop, bit_end;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (Data_Valid && !fifo_full),
    .pop   (pop),
    .wdata (P_DATA),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign Data_Ready = !fifo_full;
  assign busy       = (state != IDLE);
  assign TX_OUT     = tx_q;
  assign bit_end    = (timer == div_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      timer  <= '0;
      bit_q  <= '0;
      stop_q <= 1'b0;
      shreg  <= '0;
      tx_q   <= STOP_BIT;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      bit_q  <= bit_n;
      stop_q <= stop_n;
      shreg  <= shreg_n;
      tx_q   <= tx_n;
    end
  end

  // Frame configuration is frozen at the pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q    <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      stop2_q  <= 1'b0;
    end else if (pop) begin
      div_q    <= BAUD_DIV;
      par_en_q <= PAR_EN;
      stop2_q  <= STOP2;
      par_q    <= parity_bit(PAR_MAX_W'(fifo_rdata), PAR_TYP);
    end
  end

  always_comb begin
    state_n = state;
    tx_n    = tx_q;
    timer_n = bit_end ? '0 : timer + 1'b1;
    bit_n   = bit_q;
    stop_n  = stop_q;
    shreg_n = shreg;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_rdata;
          state_n = START;
          tx_n    = START_BIT;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n    = shreg[0];
        bit_n   = '0;
      end
      DATA: if (bit_end) begin
        if (bit_q == LAST_BIT) begin
          if (par_en_q) begin
            state_n = PARITY;
            tx_n    = par_q;
          end else begin
            state_n = STOP;
            tx_n    = STOP_BIT;
            stop_n  = 1'b0;
          end
        end else begin
          shreg_n = shreg >> 1;
          tx_n    = shreg[1];
          bit_n   = bit_q + 1'b1;
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n    = STOP_BIT;
        stop_n  = 1'b0;
      end
      STOP: if (bit_end) begin
        if (stop2_q && !stop_q) begin
          stop_n = 1'b1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = fifo_rdata;
          state_n = START;
          tx_n    = START_BIT;
        end else begin
          state_n = IDLE;
          tx_n    = STOP_BIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: bit-stream reference model
// with directed and randomized frame traffic.
module tb_uart_tx_fifo_param;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Data_Valid;
  logic [7:0]  P_DATA;
  logic        Data_Ready;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
  logic [15:0] BAUD_DIV;
  logic        TX_OUT;
  logic        busy;
  logic [2:0]  fifo_count;

  int tests = 0;
  int fails = 0;
  int busy_cnt;
  int ready_low;

  logic [7:0] push_q[$];
  logic [7:0] mq[$];
  bit         exp_q[$];
  bit         tx_log[$];

  always #5 CLK = ~CLK;

  uart_tx_fifo_param #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Data_Valid (Data_Valid),
    .P_DATA     (P_DATA),
    .Data_Ready (Data_Ready),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .BAUD_DIV   (BAUD_DIV),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole frame as a list of line levels, one entry per clock.
  function automatic void add_frame(input logic [7:0] w);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (PAR_EN) bits.push_back(($countones(w) % 2 == 1) ^ PAR_TYP);
    bits.push_back(1'b1);
    if (STOP2) bits.push_back(1'b1);
    foreach (bits[i])
      for (int r = 0; r <= int'(BAUD_DIV); r++) exp_q.push_back(bits[i]);
  endfunction

  task automatic step();
    logic       acc;
    logic [7:0] w;
    bit         etx;
    bit         ebusy;
    Data_Valid = (push_q.size() != 0);
    P_DATA     = Data_Valid ? push_q[0] : 8'($urandom);
    w          = P_DATA;
    acc        = Data_Valid && (mq.size() < DEPTH) && !RST;
    @(posedge CLK);
    if (RST) begin
      mq.delete();
      exp_q.delete();
    end else if (exp_q.size() == 0 && mq.size() != 0) begin
      add_frame(mq.pop_front());
    end
    etx   = 1'b1;
    ebusy = 1'b0;
    if (exp_q.size() != 0) begin
      etx   = exp_q.pop_front();
      ebusy = 1'b1;
    end
    if (acc) begin
      mq.push_back(w);
      void'(push_q.pop_front());
    end
    #1;
    check("tx_out", 32'(TX_OUT), 32'(etx));
    check("busy", 32'(busy), 32'(ebusy));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("data_ready", 32'(Data_Ready), 32'(mq.size() < DEPTH));
    if (busy === 1'b1) begin
      busy_cnt++;
      tx_log.push_back(TX_OUT);
    end
    if (Data_Ready === 1'b0) ready_low++;
  endtask

  task automatic clear_logs();
    busy_cnt  = 0;
    ready_low = 0;
    tx_log.delete();
  endtask

  task automatic rand_cfg();
    PAR_EN   = 1'($urandom_range(0, 1));
    PAR_TYP  = 1'($urandom_range(0, 1));
    STOP2    = 1'($urandom_range(0, 1));
    BAUD_DIV = 16'($urandom_range(0, 3));
  endtask

  initial begin
    logic [9:0] frame_bits;
    int         n;

    RST        = 1'b1;
    Data_Valid = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    STOP2      = 1'b0;
    BAUD_DIV   = '0;
    clear_logs();
    step();
    RST = 1'b0;

    // Idle line after reset
    clear_logs();
    repeat (20) step();
    check("idle_busy_cycles", busy_cnt, 0);

    // 8N1 at one bit per clock
    clear_logs();
    push_q.push_back(8'hA5);
    repeat (14) step();
    check("a5_frame_len", busy_cnt, 10);
    frame_bits = '0;
    foreach (tx_log[i]) if (i < 10) frame_bits[i] = tx_log[i];
    check("a5_frame_bits", 32'(frame_bits), 32'h34A);

    // Even parity, 4 clocks per bit
    clear_logs();
    BAUD_DIV = 16'd3;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    push_q.push_back(8'h07);
    repeat (50) step();
    check("even_frame_len", busy_cnt, 44);
    check("even_par_first", 32'(tx_log.size() > 39 && tx_log[36]), 1);
    check("even_par_last", 32'(tx_log.size() > 39 && tx_log[39]), 1);

    // Odd parity
    clear_logs();
    PAR_TYP = 1'b1;
    push_q.push_back(8'h07);
    repeat (50) step();
    check("odd_frame_len", busy_cnt, 44);
    check("odd_par_bit", 32'(tx_log.size() > 39 && !tx_log[37]), 1);

    // Burst with two stop bits through a full FIFO
    clear_logs();
    STOP2    = 1'b1;
    BAUD_DIV = '0;
    PAR_EN   = 1'b0;
    for (int i = 1; i <= 6; i++) push_q.push_back(8'(i));
    repeat (80) step();
    check("burst_busy_cycles", busy_cnt, 66);
    check("burst_ready_dropped", 32'(ready_low > 0), 1);

    // Configuration change while frame 1 is on the line
    clear_logs();
    STOP2    = 1'b0;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    BAUD_DIV = 16'd1;
    push_q.push_back(8'h3C);
    push_q.push_back(8'hC3);
    repeat (6) step();
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b1;
    BAUD_DIV = 16'd2;
    repeat (60) step();
    check("midcfg_busy_cycles", busy_cnt, 20 + 33);

    // Reset during the data bits with two words queued
    clear_logs();
    PAR_EN   = 1'b0;
    BAUD_DIV = 16'd2;
    push_q.push_back(8'h11);
    push_q.push_back(8'h22);
    push_q.push_back(8'h33);
    repeat (8) step();
    check("pre_reset_count", 32'(fifo_count), 2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    clear_logs();
    repeat (40) step();
    check("post_reset_busy", busy_cnt, 0);

    // Random traffic with occasional configuration changes
    for (int t = 0; t < 25; t++) begin
      rand_cfg();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) push_q.push_back(8'($urandom));
      for (int c = 0; c < 1000; c++) begin
        if ($urandom_range(0, 15) == 0) rand_cfg();
        step();
        if (push_q.size() == 0 && mq.size() == 0 && exp_q.size() == 0)
          break;
      end
      check("rand_drained",
            32'(push_q.size() + mq.size() + exp_q.size()), 0);
      push_q.delete();
      repeat ($urandom_range(0, 3)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
